// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and its requester-sharing front end.
//   ALU_OP_W    : width of the ALU op code
//   alu_op_e    : the ten legal ALU operations (0..9)
//   ALU_OP_MAX  : highest legal op code
//   ALU_DATA_W  : default operand/result width
//   is_illegal_op() : flags op codes outside the legal set
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_W   = 4;
    localparam int ALU_DATA_W = 32;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    localparam logic [ALU_OP_W-1:0] ALU_OP_MAX = 4'd9;

    // Codes 10..15 still reach the ALU; they are only flagged in the response.
    function automatic logic is_illegal_op(input logic [ALU_OP_W-1:0] op);
        return (op > ALU_OP_MAX);
    endfunction

endpackage : alu_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: scans the request vector starting
// at i_ptr, wrapping modulo NUM_REQ, and grants the first set bit.
//   i_req        : request vector
//   i_ptr        : highest-priority index for this cycle
//   o_grant      : one-hot grant (all zeros when nothing requests)
//   o_grant_idx  : encoded index of the grant (0 when nothing requests)
//   o_any_grant  : at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_any_grant
);

    // Rotating priority scan; the sum is one bit wider so ptr+i never overflows
    // before the modulo wrap, which also covers non-power-of-two NUM_REQ.
    always_comb begin
        logic [ID_W:0]   w_sum;
        logic [ID_W-1:0] w_j;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_sum       = '0;
        w_j         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, i_ptr} + (ID_W+1)'(i);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            end else begin
                w_sum = w_sum;
            end
            w_j = w_sum[ID_W-1:0];
            if (!o_any_grant && i_req[w_j]) begin
                o_any_grant    = 1'b1;
                o_grant[w_j]   = 1'b1;
                o_grant_idx    = w_j;
            end else begin
                o_any_grant    = o_any_grant;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one external combinational ALU between NUM_REQ requesters using
// round-robin arbitration and captures each result in a single registered,
// id-tagged response slot with its own valid/ready handshake.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_req_valid/o_req_ready : per-requester handshake (ready is one-hot)
//   i_req_a/_b/_op          : packed per-requester payloads
//   o_alu_a/_b/_op          : granted payload to the ALU (zeros when idle)
//   i_alu_data/_less/_equal : ALU result and compare flags
//   o_rsp_*                 : registered response slot and handshake
// -----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = ALU_DATA_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    output logic [NUM_REQ-1:0]          o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_b,
    input  logic [NUM_REQ*ALU_OP_W-1:0] i_req_op,
    output logic [DATA_W-1:0]           o_alu_a,
    output logic [DATA_W-1:0]           o_alu_b,
    output logic [ALU_OP_W-1:0]         o_alu_op,
    input  logic [DATA_W-1:0]           i_alu_data,
    input  logic                        i_alu_less,
    input  logic                        i_alu_equal,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic [DATA_W-1:0]           o_rsp_data,
    output logic [ID_W-1:0]             o_rsp_id,
    output logic                        o_rsp_less,
    output logic                        o_rsp_equal,
    output logic                        o_rsp_illegal
);

    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;
    logic [ID_W-1:0]    r_rsp_id;
    logic               r_rsp_less;
    logic               r_rsp_equal;
    logic               r_rsp_illegal;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_any_grant;
    logic               w_slot_free;
    logic [NUM_REQ-1:0] w_req_ready;
    logic               w_accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_req       (i_req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    // A draining slot counts as free, giving back-to-back throughput.
    assign w_slot_free = !r_rsp_valid || i_rsp_ready;

    // Ready is the one-hot grant, suppressed while the slot is blocked or in reset.
    always_comb begin
        if (w_any_grant && w_slot_free && !i_rst) begin
            w_req_ready = w_grant;
        end else begin
            w_req_ready = '0;
        end
    end

    assign w_accept    = |(i_req_valid & w_req_ready);
    assign o_req_ready = w_req_ready;

    // ALU operand mux; zeros when idle keep the ALU inputs deterministic.
    always_comb begin
        if (w_any_grant) begin
            o_alu_a  = i_req_a[w_grant_idx*DATA_W +: DATA_W];
            o_alu_b  = i_req_b[w_grant_idx*DATA_W +: DATA_W];
            o_alu_op = i_req_op[w_grant_idx*ALU_OP_W +: ALU_OP_W];
        end else begin
            o_alu_a  = '0;
            o_alu_b  = '0;
            o_alu_op = '0;
        end
    end

    // Round-robin pointer: moves to the slot after the accepted requester.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_grant_idx == ID_W'(NUM_REQ-1)) ? '0 : (w_grant_idx + ID_W'(1));
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // Response slot: load on accept (overwrites a draining entry), clear valid on a bare drain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_id      <= '0;
            r_rsp_less    <= 1'b0;
            r_rsp_equal   <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_data    <= i_alu_data;
            r_rsp_id      <= w_grant_idx;
            r_rsp_less    <= i_alu_less;
            r_rsp_equal   <= i_alu_equal;
            r_rsp_illegal <= is_illegal_op(o_alu_op);
        end else if (r_rsp_valid && i_rsp_ready) begin
            r_rsp_valid   <= 1'b0;
        end else begin
            r_rsp_valid   <= r_rsp_valid;
        end
    end

    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_id      = r_rsp_id;
    assign o_rsp_less    = r_rsp_less;
    assign o_rsp_equal   = r_rsp_equal;
    assign o_rsp_illegal = r_rsp_illegal;

endmodule : alu_share_arbiter
